// File: rtl/ibex_pkg_pext.sv
// Shared types and constants for the Pext multiplier control path.
package ibex_pkg_pext;

  typedef enum logic [1:0] {
    M32x32 = 2'b00,
    M32x16 = 2'b01,
    M16x16 = 2'b10,
    M8x8   = 2'b11
  } mult_pext_mode_e;

  typedef enum logic [1:0] {
    SEQ_IDLE   = 2'b00,
    SEQ_MUL_HI = 2'b01,
    SEQ_ACCUM  = 2'b10
  } mult_pext_seq_state_e;

  localparam logic [1:0] MCYC_1  = 2'b00;
  localparam logic [1:0] MCYC_2  = 2'b01;
  localparam logic [1:0] MCYC_1A = 2'b10;
  localparam logic [1:0] MCYC_2A = 2'b11;

  typedef struct packed {
    mult_pext_mode_e mode;
    logic [1:0]      cyc;
    logic [1:0]      accum_sub;
    logic            dsum;
    logic            crossed;
  } mult_pext_ctrl_t;

endpackage

// File: rtl/ibex_mult_pext_sequencer.sv
// Multi-cycle sequencer for the Pext multiplier: steps the datapath through
// low-half, high-half and ALU-accumulate phases and flags completion.
module ibex_mult_pext_sequencer
  import ibex_pkg_pext::*;
#(
  parameter bit RegCtrl = 1'b1
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       en_i,
  input  logic [1:0] mult_mode_i,
  input  logic [1:0] cycle_count_i,
  input  logic [1:0] accum_sub_i,
  input  logic       dsum_mult_i,
  input  logic       crossed_i,
  input  logic       accum_i,
  output logic [1:0] mult_mode_o,
  output logic       phase_hi_o,
  output logic       imd_we_o,
  output logic       imd_use_o,
  output logic       alu_accum_o,
  output logic       alu_sub_o,
  output logic       sub16_o,
  output logic       dsum_o,
  output logic       crossed_o,
  output logic       busy_o,
  output logic       valid_o
);

  mult_pext_seq_state_e state_q, state_d;
  mult_pext_ctrl_t      ctrl_q, ctrl_in, ctrl_act, ctrl_out;
  logic                 load, clear;
  logic                 phase_hi, imd_we, imd_use, alu_accum, alu_sub, valid;

  always_comb begin
    ctrl_in.mode      = mult_pext_mode_e'(mult_mode_i);
    ctrl_in.cyc       = cycle_count_i;
    ctrl_in.accum_sub = accum_sub_i;
    ctrl_in.dsum      = dsum_mult_i;
    ctrl_in.crossed   = crossed_i;
  end

  // The first mult cycle runs in IDLE, so it always sees the live inputs.
  assign ctrl_act = (state_q == SEQ_IDLE || !RegCtrl) ? ctrl_in : ctrl_q;

  always_comb begin
    state_d   = state_q;
    load      = 1'b0;
    clear     = 1'b0;
    ctrl_out  = '0;
    phase_hi  = 1'b0;
    imd_we    = 1'b0;
    imd_use   = 1'b0;
    alu_accum = 1'b0;
    alu_sub   = 1'b0;
    valid     = 1'b0;
    unique case (state_q)
      SEQ_IDLE: begin
        if (en_i) begin
          ctrl_out = ctrl_act;
          unique case (ctrl_act.cyc)
            MCYC_1:  valid = 1'b1;
            MCYC_1A: begin imd_we = 1'b1; load = 1'b1; state_d = SEQ_ACCUM;  end
            default: begin imd_we = 1'b1; load = 1'b1; state_d = SEQ_MUL_HI; end
          endcase
        end
      end
      SEQ_MUL_HI: begin
        ctrl_out = ctrl_act;
        phase_hi = 1'b1;
        imd_use  = 1'b1;
        if (!en_i) begin
          clear   = 1'b1;
          state_d = SEQ_IDLE;
        end else if (ctrl_act.cyc == MCYC_2A) begin
          // Full 32x32 product replaces the partial one before accumulation.
          imd_we  = 1'b1;
          state_d = SEQ_ACCUM;
        end else begin
          valid   = 1'b1;
          state_d = SEQ_IDLE;
        end
      end
      SEQ_ACCUM: begin
        ctrl_out = ctrl_act;
        alu_sub  = ctrl_act.accum_sub[1];
        state_d  = SEQ_IDLE;
        if (!en_i) begin
          clear = 1'b1;
        end else begin
          alu_accum = 1'b1;
          valid     = 1'b1;
        end
      end
      default: state_d = SEQ_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= SEQ_IDLE;
      ctrl_q  <= '0;
    end else begin
      state_q <= state_d;
      if (clear)     ctrl_q <= '0;
      else if (load) ctrl_q <= ctrl_in;
    end
  end

  assign mult_mode_o = rst_i ? M32x32 : ctrl_out.mode;
  assign phase_hi_o  = !rst_i && phase_hi;
  assign imd_we_o    = !rst_i && imd_we;
  assign imd_use_o   = !rst_i && imd_use;
  assign alu_accum_o = !rst_i && alu_accum;
  assign alu_sub_o   = !rst_i && alu_sub;
  assign sub16_o     = !rst_i && ctrl_out.accum_sub[0];
  assign dsum_o      = !rst_i && ctrl_out.dsum;
  assign crossed_o   = !rst_i && ctrl_out.crossed;
  assign busy_o      = !rst_i && (state_q != SEQ_IDLE);
  assign valid_o     = !rst_i && valid;

  // Decoder contract: accumulating ops are exactly the codes with an ALU cycle,
  // and two-cycle multiplies only exist for the full 32x32 mode.
  a_accum_matches_code: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == SEQ_IDLE && en_i) |-> (accum_i == cycle_count_i[1]));
  a_two_cycle_is_32x32: assert property (@(posedge clk_i) disable iff (rst_i)
    (state_q == SEQ_IDLE && en_i && cycle_count_i[0]) |-> (mult_mode_i == M32x32));

endmodule

// File: tb/tb_ibex_mult_pext_sequencer.sv
// Directed-vector scoreboard bench for the Pext multiplier sequencer.
module tb_ibex_mult_pext_sequencer;

  logic       clk = 1'b0;
  logic       rst, en, dsum, crossed, accum;
  logic [1:0] mode, cyc, asub;
  logic [1:0] mult_mode_o;
  logic       phase_hi_o, imd_we_o, imd_use_o, alu_accum_o, alu_sub_o;
  logic       sub16_o, dsum_o, crossed_o, busy_o, valid_o;

  typedef struct {
    logic [11:0] exp;
    string       name;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  ibex_mult_pext_sequencer #(.RegCtrl(1'b1)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .mult_mode_i(mode), .cycle_count_i(cyc),
    .accum_sub_i(asub), .dsum_mult_i(dsum), .crossed_i(crossed), .accum_i(accum),
    .mult_mode_o(mult_mode_o), .phase_hi_o(phase_hi_o), .imd_we_o(imd_we_o),
    .imd_use_o(imd_use_o), .alu_accum_o(alu_accum_o), .alu_sub_o(alu_sub_o),
    .sub16_o(sub16_o), .dsum_o(dsum_o), .crossed_o(crossed_o), .busy_o(busy_o),
    .valid_o(valid_o)
  );

  // Packed output order: mode[11:10] ph we use acc sub s16 ds cr busy vld
  function automatic logic [11:0] e(input logic [1:0] m, input logic ph, we, us, ac, sb,
                                    s16, ds, cr, bz, vl);
    return {m, ph, we, us, ac, sb, s16, ds, cr, bz, vl};
  endfunction

  // Drive one cycle of inputs and queue the outputs expected in that cycle.
  task automatic drv(input logic r, input logic n, input logic [1:0] m, c, s,
                     input logic d, x, a, input logic [11:0] ex, input string nm);
    exp_t t;
    @(posedge clk);
    #1;
    rst = r; en = n; mode = m; cyc = c; asub = s; dsum = d; crossed = x; accum = a;
    t.exp = ex; t.name = nm;
    q.push_back(t);
  endtask

  task automatic idle(input string nm);
    drv(0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 12'h000, nm);
  endtask

  always @(negedge clk) begin
    if (q.size() != 0) begin
      exp_t t;
      logic [11:0] act;
      t   = q.pop_front();
      act = {mult_mode_o, phase_hi_o, imd_we_o, imd_use_o, alu_accum_o, alu_sub_o,
             sub16_o, dsum_o, crossed_o, busy_o, valid_o};
      n_cmp++;
      if (act !== t.exp) begin
        n_err++;
        $display("FAIL %s: got %b expected %b", t.name, act, t.exp);
      end
    end
  end

  initial begin
    rst = 1; en = 0; mode = 0; cyc = 0; asub = 0; dsum = 0; crossed = 0; accum = 0;
    // Reset forces all outputs low even with a request pending.
    drv(1, 1, 2'd3, 2'd3, 2'd3, 1, 1, 1, 12'h000, "reset_en");
    drv(1, 0, 2'd0, 2'd0, 2'd0, 0, 0, 0, 12'h000, "reset");
    idle("idle");

    // Code 00, M16x16: single-cycle op.
    drv(0, 1, 2'd2, 2'b00, 2'b01, 1, 0, 0, e(2, 0,0,0,0,0, 1,1,0, 0,1), "c00_c0");
    idle("c00_after");

    // Code 01, M32x32; crossed changed in cycle 1 must be ignored.
    drv(0, 1, 2'd0, 2'b01, 2'b00, 0, 1, 0, e(0, 0,1,0,0,0, 0,0,1, 0,0), "c01_c0");
    drv(0, 1, 2'd0, 2'b01, 2'b00, 0, 0, 0, e(0, 1,0,1,0,0, 0,0,1, 1,1), "c01_c1");
    idle("c01_c2");

    // Code 11, KMMSB.
    drv(0, 1, 2'd0, 2'b11, 2'b10, 1, 0, 1, e(0, 0,1,0,0,0, 0,1,0, 0,0), "c11_c0");
    drv(0, 1, 2'd0, 2'b11, 2'b10, 1, 0, 1, e(0, 1,1,1,0,0, 0,1,0, 1,0), "c11_c1");
    drv(0, 1, 2'd0, 2'b11, 2'b10, 1, 0, 1, e(0, 0,0,0,1,1, 0,1,0, 1,1), "c11_c2");
    idle("c11_c3");

    // Code 10; inputs switch to code 00 in cycle 1 and must be ignored.
    drv(0, 1, 2'd0, 2'b10, 2'b01, 0, 0, 1, e(0, 0,1,0,0,0, 1,0,0, 0,0), "c10_c0");
    drv(0, 1, 2'd0, 2'b00, 2'b00, 0, 0, 0, e(0, 0,0,0,1,0, 1,0,0, 1,1), "c10_c1");
    idle("c10_c2");

    // Code 11 killed in MUL_HI, then a code-00 op right away.
    drv(0, 1, 2'd0, 2'b11, 2'b00, 0, 0, 1, e(0, 0,1,0,0,0, 0,0,0, 0,0), "kill_c0");
    drv(0, 0, 2'd0, 2'b11, 2'b00, 0, 0, 1, e(0, 1,0,1,0,0, 0,0,0, 1,0), "kill_c1");
    drv(0, 1, 2'd3, 2'b00, 2'b00, 0, 0, 0, e(3, 0,0,0,0,0, 0,0,0, 0,1), "kill_c2_new");
    idle("kill_c3");

    // Code 10 killed in ACCUM.
    drv(0, 1, 2'd0, 2'b10, 2'b00, 0, 0, 1, e(0, 0,1,0,0,0, 0,0,0, 0,0), "killa_c0");
    drv(0, 0, 2'd0, 2'b10, 2'b00, 0, 0, 1, e(0, 0,0,0,0,0, 0,0,0, 1,0), "killa_c1");
    idle("killa_c2");

    // Code 11 aborted by reset in cycle 1.
    drv(0, 1, 2'd0, 2'b11, 2'b10, 1, 1, 1, e(0, 0,1,0,0,0, 0,1,1, 0,0), "rst_c0");
    drv(1, 1, 2'd0, 2'b11, 2'b10, 1, 1, 1, 12'h000, "rst_c1");
    idle("rst_c2");

    // Back-to-back code-01 ops with en held high.
    drv(0, 1, 2'd0, 2'b01, 2'b00, 0, 0, 0, e(0, 0,1,0,0,0, 0,0,0, 0,0), "b2b_c0");
    drv(0, 1, 2'd0, 2'b01, 2'b00, 0, 0, 0, e(0, 1,0,1,0,0, 0,0,0, 1,1), "b2b_c1");
    drv(0, 1, 2'd0, 2'b01, 2'b00, 0, 0, 0, e(0, 0,1,0,0,0, 0,0,0, 0,0), "b2b_c2");
    drv(0, 1, 2'd0, 2'b01, 2'b00, 0, 0, 0, e(0, 1,0,1,0,0, 0,0,0, 1,1), "b2b_c3");
    idle("b2b_c4");
    idle("final");

    for (int i = 0; i < 10 && q.size() != 0; i++) @(posedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: %0d entries left, expected 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
